// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The 64-bit result is computed when the operation is accepted and committed after the busy period.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   res;
    logic          wr;

    logic          sgn, accept, done;
    logic [63:0]   ma, mb, prod;
    logic [31:0]   ua, ub, ubd, q, r, q_s, r_s;

    // Sign-extending to 64 bits lets one multiplier serve both MULT and MULTU.
    assign sgn  = !op[0];
    assign ma   = {sgn ? {32{rs_value[31]}} : 32'd0, rs_value};
    assign mb   = {sgn ? {32{rt_value[31]}} : 32'd0, rt_value};
    assign prod = ma * mb;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows the dividend.
    assign ua  = sgn && rs_value[31] ? -rs_value : rs_value;
    assign ub  = sgn && rt_value[31] ? -rt_value : rt_value;
    assign ubd = ub == 32'd0 ? 32'd1 : ub;
    assign q   = ua / ubd;
    assign r   = ua % ubd;
    assign q_s = sgn && (rs_value[31] ^ rt_value[31]) ? -q : q;
    assign r_s = sgn && rs_value[31] ? -r : r;

    assign busy   = state != IDLE;
    assign accept = state == IDLE && start;
    assign done   = busy && cnt == CW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = busy ? cnt - CW'(1) : cnt;
        if (accept && !op[2]) begin
            state_n = op[1] ? DIV : MUL;
            cnt_n   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (done) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
            wr    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept && !op[2]) begin
                res <= op[1] ? {r_s, q_s} : prod;
                wr  <= !(op[1] && rt_value == 32'd0);
            end
            if (accept && op == 3'd4) hi <= rs_value;
            if (accept && op == 3'd5) lo <= rs_value;
            if (done && wr) {hi, lo} <= res;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed checks of mdu arithmetic, busy timing, MTHI/MTLO, ignored starts and async reset.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd6;
    logic [31:0] rs_value = '0;
    logic [31:0] rt_value = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int fails = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_value(rs_value), .rt_value(rt_value),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present the request for one cycle, check busy/hold each cycle, then the result.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; op = o; rs_value = a; rt_value = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " hi_hold"}, hi, exp_hi);
            chk({tag, " lo_hold"}, lo, exp_lo);
            @(negedge clk);
        end
        chk({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    task automatic mt_pair(input logic [31:0] h, input logic [31:0] l);
        start = 1'b1; op = 3'd4; rs_value = h;
        @(negedge clk);
        op = 3'd5; rs_value = l;
        chk("mthi hi", hi, h);
        chk("mthi lo_hold", lo, exp_lo);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("mtlo lo", lo, l);
        chk("mtlo hi_hold", hi, h);
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        exp_hi = h;
        exp_lo = l;
    endtask

    initial begin
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // No-op start must leave everything alone.
        start = 1'b1; op = 3'd7; rs_value = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("nop busy", {31'd0, busy}, 32'd0);
        chk("nop hi", hi, 32'd0);
        chk("nop lo", lo, 32'd0);

        run("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        mt_pair(32'hDEAD_BEEF, 32'h1234_5678);
        mt_pair(32'h11, 32'h22);
        run("divu_zero", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);

        // MULT with an MTLO request during busy cycle 2 that must be ignored.
        start = 1'b1; op = 3'd0; rs_value = 32'd7; rt_value = 32'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs_value = 32'd5;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("ign busy", {31'd0, busy}, 32'd1);
        chk("ign lo_hold", lo, 32'h22);
        repeat (3) @(negedge clk);
        chk("ign busy_fall", {31'd0, busy}, 32'd0);
        chk("ign hi", hi, 32'd0);
        chk("ign lo", lo, 32'd42);
        exp_hi = 32'd0;
        exp_lo = 32'd42;
        run("b2b", 3'd0, 32'h0001_2345, 32'h0001_0000, 5, 32'd1, 32'h2345_0000);

        // Async reset mid DIV (cycle 4): outputs clear without a clock edge, no later commit.
        start = 1'b1; op = 3'd2; rs_value = 32'd100; rt_value = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pre busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst after busy", {31'd0, busy}, 32'd0);
        chk("rst after hi", hi, 32'd0);
        chk("rst after lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run("post_rst divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the E stage of the 5-stage pipeline, alongside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage decoder and owns the architectural HI/LO registers. It exposes a `busy` handshake so the hazard unit can stall following HI/LO accesses and MD instructions while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  one-cycle request; `op` and operands valid this cycle.
- `op`  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `rs_value`  input  32  forwarded rs operand (dividend / multiplicand / MT source).
- `rt_value`  input  32  forwarded rt operand (divisor / multiplier).
- `busy`  output  1  operation in flight; registered.
- `hi`  output  32  architectural HI register.
- `lo`  output  32  architectural LO register.

## Operation
- States: IDLE, MUL, DIV. Down-counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, `start` with op 0/1: latch operands and the pending 64-bit result {hi_n, lo_n}; `cnt`←MULT_CYCLES; go to MUL. Op 2/3: same with DIV_CYCLES; go to DIV.
- IDLE, `start` with op 4: `hi`←`rs_value` at this edge. Op 5: `lo`←`rs_value`. No state change, `busy` stays 0.
- IDLE, `start` with op 6/7: no effect.
- MUL/DIV: `cnt` decrements each cycle; when `cnt`==1 at an edge, `hi`/`lo`←pending result, go to IDLE.
- `start` while not IDLE: ignored entirely (hazard unit must stall on `start || busy`); in-flight op and pending result unaffected.
- Arithmetic:
  - MULT: signed 32×32→64; `hi`=upper 32 bits, `lo`=lower 32 bits. MULTU: unsigned.
  - DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with sign of dividend. DIVU: unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (32-bit wrap, no trap).
  - Divisor 0 (DIV or DIVU): full busy period runs, `hi`/`lo` left unchanged.
- `hi`/`lo` change only at the completion edge or an MTHI/MTLO edge; never mid-operation.
- `reset` (any time, including mid-op): `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, pending result discarded.

## Timing
- `start` sampled at edge E0 (end of cycle 0).
- `busy` is 1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES) and 0 in cycle N+1.
- New `hi`/`lo` are visible from cycle N+1, the same cycle `busy` falls.
- A new `start` is accepted no earlier than cycle N+1 (back-to-back with no gap).
- MTHI/MTLO: one-edge latency; the value is visible the next cycle, `busy` never asserted.
- Reset values: `busy`=0, `hi`=0x00000000, `lo`=0x00000000. Deassertion takes effect at the next edge with no extra delay cycle.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU rs=7, rt=2 → `lo`=3, `hi`=1.
- Divide boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 5 / 0 with prior `hi`=0x11, `lo`=0x22 → `busy` 10 cycles, then `hi`=0x11, `lo`=0x22 unchanged.
- MTHI rs=0xDEADBEEF then MTLO rs=0x12345678 on consecutive cycles → `hi`/`lo` updated one edge after each, `busy` stays 0.
- MULT started, `start`+MTLO 0x5 asserted during busy cycle 2 → MTLO ignored, `lo` = MULT product at completion. A second MULT issued in cycle N+1 is accepted.
- DIV in flight, `reset` pulsed asynchronously mid-cycle 4 → `busy`, `hi`, `lo` drop to 0 immediately without a clock edge. After release, no completion write occurs.
